bcd_serial_adder: RTL
=====================

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits per operand (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have ports a and b, input, 4*DIGITS bits each: BCD operands, digit 0 in bits [3:0].
REQ-006 The block SHALL have port cin, input, 1 bit: carry into digit 0.
REQ-007 The block SHALL have port busy, output, 1 bit: high while digits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-009 The block SHALL have port sum, output, 4*DIGITS bits: BCD result.
REQ-010 The block SHALL have port cout, output, 1 bit: decimal carry out of the most significant digit.
REQ-011 The block SHALL have port err, output, 1 bit: an operand digit exceeded 9.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE; on acceptance a, b and cin are latched, the digit index is cleared to 0, err is cleared, and the next state is ADD.
REQ-014 start asserted in ADD SHALL be ignored, with no effect on latched operands or progress.
REQ-015 In ADD, each cycle SHALL process one digit, least-significant first: T = a_i + b_i + carry (5-bit); if T > 9 then digit = T - 10 and carry = 1, else digit = T and carry = 0.
REQ-016 If a_i > 9 or b_i > 9 at any processed digit, a sticky error flag SHALL be set for the current operation.
REQ-017 After digit DIGITS-1 is processed, the next state SHALL be DONE; DONE lasts exactly one cycle, then returns to IDLE unless start is accepted.
REQ-018 Latency: if start is sampled at edge k, ADD SHALL occupy edges k+1..k+DIGITS and done SHALL be high for exactly the cycle following edge k+DIGITS.
REQ-019 busy SHALL be high exactly while the state is ADD.
REQ-020 sum, cout and err SHALL update only on entry to DONE and SHALL hold until the next entry to DONE, reset, or start acceptance (which clears err only).
REQ-021 If the error flag is set at completion, then sum SHALL be all zeros, cout = 0 and err = 1.
REQ-022 Digit results SHALL be collected in an internal shift/result register, so partial results never appear on sum.

Reset
REQ-023 While rst_n = 0, the block SHALL immediately enter IDLE with busy = 0, done = 0, sum = 0, cout = 0, err = 0, the digit index = 0, and all latched operands = 0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse; operation resumes from IDLE on the first edge after rst_n rises.

Structure
REQ-025 A shared package SHALL hold the state enumeration (IDLE, ADD, DONE) and the BCD constants (digit maximum 9, correction 10).
REQ-026 One sub-module SHALL exist, bcd_digit_step: a combinational single-digit step with inputs digit a, digit b and carry in, and outputs digit, carry out and invalid; the controller instantiates it once.

Verification
REQ-027 The bench SHALL check this case: a=1234, b=8766, cin=0, start at edge k -> done in the cycle after edge k+4, sum=0000, cout=1, err=0.
REQ-028 The bench SHALL check this case: a=0456, b=0123, cin=1 -> sum=0580, cout=0, busy high for exactly 4 cycles.
REQ-029 The bench SHALL check this case: a=9999, b=0000, cin=1 -> sum=0000, cout=1.
REQ-030 The bench SHALL check this case: a=00A0 (hex digit 1 invalid), b=0001 -> err=1, sum=0000, cout=0; the next valid start clears err.
REQ-031 The bench SHALL check this case: start re-pulsed during ADD with different operands -> ignored; result matches the first operands.
REQ-032 The bench SHALL check this case: rst_n low at the second ADD cycle -> all outputs 0 immediately, no done; a subsequent start of 0001+0001 -> sum=0002.

Source files
------------

// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and decimal constants for the digit-serial BCD adder.
package bcd_serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX  = 4'd9;
   localparam logic [4:0] BCD_CORR = 5'd10;

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of addition: binary add, then decimal correction on overflow past 9.
module bcd_digit_step
   import bcd_serial_adder_pkg::*;
(
   input  logic [3:0] a_dig,
   input  logic [3:0] b_dig,
   input  logic       cin,
   output logic [3:0] dig,
   output logic       cout,
   output logic       invalid
);

   logic [4:0] t;

   assign t       = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, cin};
   assign invalid = (a_dig > BCD_MAX) || (b_dig > BCD_MAX);

   always_comb begin
      dig  = t[3:0];
      cout = 1'b0;
      if (t > {1'b0, BCD_MAX}) begin
         dig  = 4'(t - BCD_CORR);
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per cycle LSD first, result published in one step on DONE.
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state, state_nxt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] a_q, b_q, res_q, res_next;
   logic                carry_q, err_flag;
   logic [3:0]          step_dig;
   logic                step_cout, step_inv;
   logic                accept, last_dig, err_nxt;

   assign accept   = start && ((state == IDLE) || (state == DONE));
   assign last_dig = (state == ADD) && (idx == IW'(DIGITS - 1));
   assign err_nxt  = err_flag | step_inv;

   bcd_digit_step u_step (
      .a_dig   (a_q[3:0]),
      .b_dig   (b_q[3:0]),
      .cin     (carry_q),
      .dig     (step_dig),
      .cout    (step_cout),
      .invalid (step_inv)
   );

   // New digit enters at the top so that after DIGITS shifts digit 0 sits in [3:0].
   if (DIGITS == 1) begin : g_one
      assign res_next = step_dig;
   end else begin : g_multi
      assign res_next = {step_dig, res_q[4*DIGITS-1:4]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ADD;
         ADD:     if (last_dig) state_nxt = DONE;
         DONE:    state_nxt = start ? ADD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ADD);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         err_flag <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         err      <= 1'b0;
      end else if (accept) begin
         a_q      <= a;
         b_q      <= b;
         carry_q  <= cin;
         err_flag <= 1'b0;
         idx      <= '0;
         err      <= 1'b0;
      end else if (state == ADD) begin
         a_q      <= a_q >> 4;
         b_q      <= b_q >> 4;
         carry_q  <= step_cout;
         err_flag <= err_nxt;
         res_q    <= res_next;
         idx      <= idx + IW'(1);
         // Any bad digit poisons the whole result.
         if (last_dig) begin
            sum  <= err_nxt ? '0 : res_next;
            cout <= err_nxt ? 1'b0 : step_cout;
            err  <= err_nxt;
         end
      end
   end

endmodule
